bw_io_ddr_strobe_test_ctl: RTL and testbench

Sequencer for the DDR pad strobe test mux: it drives the mux select (`testmode_l`) and the test strobe (`strobe`) so the pad strobe path can be switched into test mode without glitches. On request, it issues a programmed burst of strobe pulses and then returns the pad to functional mode. There is one instance per DDR byte lane, clocked by the lane's core clock. Every output is a flop output, so the mux select and strobe never glitch.

---
 rtl/bw_io_ddr_strobe_test_ctl.sv | 139 +++++++++++++
 tb/tb_bw_io_ddr_strobe_test_ctl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_ddr_strobe_test_ctl.sv
// rtl/bw_io_ddr_strobe_test_ctl.sv - glitch-free sequencer for the DDR pad strobe test mux
module bw_io_ddr_strobe_test_ctl #(
  parameter int GUARD_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             test_req,
  input  logic             test_abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [3:0]       half_period,
  output logic             testmode_l,
  output logic             strobe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTER = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    EXIT  = 3'd4
  } state_t;

  // Last guard count; guard cycles run 0..GUARD_CYC-1 in ENTER and EXIT.
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

  state_t           state;
  logic [3:0]       guard_cnt;
  logic [3:0]       phase_cnt;
  logic [3:0]       hp_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] pulse_inc;

  // Count after the pulse that is just finishing; never exceeds len_q so it cannot wrap.
  assign pulse_inc = pulse_cnt + CNT_W'(1);

  // Sequencer: state, counters and every output are flops so the mux select never glitches.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      guard_cnt  <= '0;
      phase_cnt  <= '0;
      hp_q       <= '0;
      len_q      <= '0;
      pulse_cnt  <= '0;
      testmode_l <= 1'b1;
      strobe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also covers the done cycle: a still-high request is taken here.
          if (test_req) begin
            len_q      <= burst_len;
            hp_q       <= half_period;
            pulse_cnt  <= '0;
            guard_cnt  <= '0;
            phase_cnt  <= '0;
            testmode_l <= 1'b0;
            busy       <= 1'b1;
            state      <= ENTER;
          end
        end
        ENTER: begin
          if (test_abort) begin
            guard_cnt <= '0;
            state     <= EXIT;
          end else if (guard_cnt == GUARD_LAST) begin
            guard_cnt <= '0;
            phase_cnt <= '0;
            if (len_q == '0) begin
              state <= EXIT;
            end else begin
              strobe <= 1'b1;
              state  <= HIGH;
            end
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        HIGH: begin
          if (test_abort) begin
            strobe    <= 1'b0;
            guard_cnt <= '0;
            state     <= EXIT;
          end else if (phase_cnt == hp_q) begin
            strobe    <= 1'b0;
            phase_cnt <= '0;
            state     <= LOW;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        LOW: begin
          // An abort wins even on the last LOW cycle, so that pulse is not counted.
          if (test_abort) begin
            guard_cnt <= '0;
            state     <= EXIT;
          end else if (phase_cnt == hp_q) begin
            pulse_cnt <= pulse_inc;
            phase_cnt <= '0;
            if (pulse_inc == len_q) begin
              guard_cnt <= '0;
              state     <= EXIT;
            end else begin
              strobe <= 1'b1;
              state  <= HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        EXIT: begin
          if (guard_cnt == GUARD_LAST) begin
            guard_cnt  <= '0;
            testmode_l <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + 4'd1;
          end
        end
        default: begin
          strobe     <= 1'b0;
          testmode_l <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bw_io_ddr_strobe_test_ctl.sv
// tb/tb_bw_io_ddr_strobe_test_ctl.sv - self-checking bench for bw_io_ddr_strobe_test_ctl
module tb_bw_io_ddr_strobe_test_ctl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       test_req;
  logic       test_abort;
  logic [7:0] burst_len;
  logic [3:0] half_period;
  logic       testmode_l;
  logic       strobe;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bw_io_ddr_strobe_test_ctl #(.GUARD_CYC(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .test_req    (test_req),
    .test_abort  (test_abort),
    .burst_len   (burst_len),
    .half_period (half_period),
    .testmode_l  (testmode_l),
    .strobe      (strobe),
    .busy        (busy),
    .done        (done),
    .pulse_cnt   (pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bl;
    logic [3:0] hp;
    int         abort_pulse;  // 0 none, -1 first ENTER cycle, n = first HIGH cycle of pulse n
    int         exp_tm_low;
    int         exp_rises;
    int         exp_hi;
    int         exp_pcnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge of the first ENTER cycle.
  task automatic start(input logic [7:0] bl, input logic [3:0] hp, input bit hold);
    @(negedge clk);
    burst_len   = bl;
    half_period = hp;
    test_req    = 1'b1;
    @(negedge clk);
    if (!hold) test_req = 1'b0;
  endtask

  // Samples one cycle per negedge from the current cycle until the done cycle.
  task automatic measure(input int abort_pulse, output int tm_low, output int rises,
                         output int hi, output int lat, output int abort_ok,
                         output int unsafe, output int busy_bad, output int done_tm_bad,
                         output int timed_out);
    logic prev_tm  = 1'b1;
    logic prev_st  = 1'b0;
    logic prev_chg = 1'b0;
    logic chg;
    bit   pend     = 1'b0;
    bit   aborted  = 1'b0;
    tm_low = 0; rises = 0; hi = 0; lat = -1; abort_ok = -1;
    unsafe = 0; busy_bad = 0; done_tm_bad = 0; timed_out = 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (pend) begin
        abort_ok   = (strobe == 1'b0) ? 1 : 0;
        test_abort = 1'b0;
        pend       = 1'b0;
      end
      if (busy == testmode_l) busy_bad++;
      chg = (testmode_l != prev_tm);
      if ((chg && (strobe || prev_st)) || (prev_chg && strobe)) unsafe++;
      if (done) begin
        if (!testmode_l) done_tm_bad++;
        timed_out = 0;
        break;
      end
      if (!testmode_l) tm_low++;
      if (strobe) begin
        hi++;
        if (!prev_st) begin
          rises++;
          if (rises == 1) lat = tm_low - 1;
        end
      end
      if (!aborted && ((abort_pulse == -1 && cyc == 0) ||
                       (abort_pulse > 0 && strobe && rises == abort_pulse))) begin
        test_abort = 1'b1;
        pend       = 1'b1;
        aborted    = 1'b1;
      end
      prev_tm  = testmode_l;
      prev_st  = strobe;
      prev_chg = chg;
    end
    test_abort = 1'b0;
  endtask

  int tm_low, rises, hi, lat, abort_ok, unsafe, busy_bad, done_tm_bad, timed_out, dones;

  initial begin
    vecs[0] = '{8'd3,   4'd1,  0, 20,   3,   6,    3};
    vecs[1] = '{8'd0,   4'd5,  0, 8,    0,   0,    0};
    vecs[2] = '{8'd1,   4'd0,  0, 10,   1,   1,    1};
    vecs[3] = '{8'd2,   4'd15, 0, 72,   2,   32,   2};
    vecs[4] = '{8'd10,  4'd0,  5, 17,   5,   5,    4};
    vecs[5] = '{8'd4,   4'd3,  2, 17,   2,   5,    1};
    vecs[6] = '{8'd5,   4'd2, -1, 5,    0,   0,    0};
    vecs[7] = '{8'd255, 4'd15, 0, 8168, 255, 4080, 255};

    rst_l = 1'b0; test_req = 1'b0; test_abort = 1'b0;
    burst_len = '0; half_period = '0;
    repeat (3) @(negedge clk);
    check("rst_testmode_l", int'(testmode_l), 1);
    check("rst_strobe", int'(strobe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse_cnt", int'(pulse_cnt), 0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_testmode_l", int'(testmode_l), 1);

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].bl, vecs[i].hp, 1'b0);
      check($sformatf("v%0d_busy_first", i), int'(busy), 1);
      measure(vecs[i].abort_pulse, tm_low, rises, hi, lat, abort_ok, unsafe, busy_bad,
              done_tm_bad, timed_out);
      check($sformatf("v%0d_timeout", i), timed_out, 0);
      dones = timed_out ? 0 : 1;
      repeat (3) begin
        @(negedge clk);
        if (done) dones++;
      end
      check($sformatf("v%0d_tm_low", i), tm_low, vecs[i].exp_tm_low);
      check($sformatf("v%0d_pulses", i), rises, vecs[i].exp_rises);
      check($sformatf("v%0d_hi_cycles", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_pulse_cnt", i), int'(pulse_cnt), vecs[i].exp_pcnt);
      check($sformatf("v%0d_done_count", i), dones, 1);
      check($sformatf("v%0d_done_testmode", i), done_tm_bad, 0);
      check($sformatf("v%0d_unsafe", i), unsafe, 0);
      check($sformatf("v%0d_busy_track", i), busy_bad, 0);
      if (vecs[i].exp_rises > 0 && vecs[i].abort_pulse != -1)
        check($sformatf("v%0d_latency", i), lat, 4);
      if (vecs[i].abort_pulse != 0)
        check($sformatf("v%0d_abort_strobe", i), abort_ok, 1);
    end

    // Back-to-back with held request; parameters change right after acceptance.
    start(8'd2, 4'd1, 1'b1);
    burst_len   = 8'd7;
    half_period = 4'd9;
    measure(0, tm_low, rises, hi, lat, abort_ok, unsafe, busy_bad, done_tm_bad, timed_out);
    check("b2b1_timeout", timed_out, 0);
    check("b2b1_tm_low", tm_low, 16);
    check("b2b1_pulses", rises, 2);
    check("b2b1_hi_cycles", hi, 4);
    check("b2b1_pulse_cnt", int'(pulse_cnt), 2);
    @(negedge clk);
    check("b2b_reenter_testmode", int'(testmode_l), 0);
    check("b2b_reenter_busy", int'(busy), 1);
    test_req = 1'b0;
    measure(0, tm_low, rises, hi, lat, abort_ok, unsafe, busy_bad, done_tm_bad, timed_out);
    check("b2b2_timeout", timed_out, 0);
    check("b2b2_tm_low", tm_low, 148);
    check("b2b2_pulses", rises, 7);
    check("b2b2_hi_cycles", hi, 70);
    check("b2b2_pulse_cnt", int'(pulse_cnt), 7);
    check("b2b2_unsafe", unsafe, 0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a HIGH phase.
    start(8'd5, 4'd3, 1'b0);
    timed_out = 1;
    for (int c = 0; c < 50; c++) begin
      if (strobe) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    check("rsthigh_reached", timed_out, 0);
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("rsthigh_testmode_l", int'(testmode_l), 1);
    check("rsthigh_strobe", int'(strobe), 0);
    check("rsthigh_busy", int'(busy), 0);
    check("rsthigh_pulse_cnt", int'(pulse_cnt), 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_l = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rsthigh_no_done", dones, 0);
    check("rsthigh_idle_testmode", int'(testmode_l), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
